// File: rtl/lib_sync_filter.sv
// lib_sync_filter: multi-channel synchroniser with per-bit stability filter and registered edge pulses
module lib_sync_filter #(
  parameter int              WIDTH    = 1,
  parameter int              STAGES   = 2,
  parameter int              FILT_CYC = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             CHG
);
  localparam int            CW   = FILT_CYC > 1 ? $clog2(FILT_CYC) : 1;
  localparam logic [CW-1:0] CMAX = CW'(FILT_CYC - 1);
  logic [WIDTH-1:0] sync_q [STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] s_out, upd_d, q_q, q_d, rise_q, fall_q;
  logic             chg_q;
  assign s_out = sync_q[STAGES-1];
  // plain flop chain per bit, nothing between stages
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < STAGES; k++) sync_q[k] <= RST_VAL;
    end else begin
      sync_q[0] <= D;
      for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end
  // a new level is accepted once it has been seen FILT_CYC cycles in a row; any return to Q clears the count
  always_comb begin
    upd_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd_d[i] = (s_out[i] != q_q[i]) && (cnt_q[i] == CMAX);
      cnt_d[i] = (s_out[i] == q_q[i] || upd_d[i]) ? '0 : cnt_q[i] + CW'(1);
    end
    q_d = (q_q & ~upd_d) | (s_out & upd_d);
  end
  // filter state and edge pulses all update on the same edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      q_q    <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      q_q    <= q_d;
      rise_q <= upd_d & s_out;
      fall_q <= upd_d & ~s_out;
      chg_q  <= |upd_d;
    end
  end
  assign Q    = q_q;
  assign RISE = rise_q;
  assign FALL = fall_q;
  assign CHG  = chg_q;
endmodule

// File: doc/lib_sync_filter.md
Name: lib_sync_filter

Overview:
Multi-channel parametrised synchroniser with a configurable number of flip-flop stages, a per-channel stability (glitch) filter and registered edge-detect outputs. Each bit of D is an independent asynchronous level signal, for example a PMU interrupt line or a status flag from another clock domain. The block brings each bit into the CLK domain, suppresses pulses shorter than FILT_CYC cycles, and reports each accepted transition as a single-cycle RISE or FALL pulse.

Parameters:
WIDTH, 1, number of independent channels (bits); range 1..64.
STAGES, 2, synchroniser flip-flops per channel; range 2..4.
FILT_CYC, 1, consecutive synchronised cycles a new level must persist before Q accepts it; range 1..255; 1 means no filtering.
RST_VAL, {WIDTH{1'b0}}, reset value of the sync chain and of Q, per bit.

Ports:
CLK  input  1  single clock; all state updates on its rising edge.
RST  input  1  synchronous, active-high reset.
D  input  WIDTH  asynchronous level inputs, one per channel.
Q  output  WIDTH  filtered, synchronised levels (registered).
RISE  output  WIDTH  one-cycle pulse per channel when Q goes 0->1 (registered).
FALL  output  WIDTH  one-cycle pulse per channel when Q goes 1->0 (registered).
CHG  output  1  OR-reduction of (RISE | FALL), registered in the same cycle as RISE/FALL.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST. RST is sampled only at a CLK rising edge.
- Reset values:
  - all sync stages and Q = RST_VAL;
  - filter counters = 0;
  - RISE, FALL, CHG = 0.
- RST has priority over every other event. Asserting RST mid-filter discards the pending count, produces no pulse and forces Q to RST_VAL.
- Sync chain, per bit: s[0] <= D and s[k] <= s[k-1]. The synchronised value is s_out = s[STAGES-1]. No logic is placed between chain stages.
- Filter, per bit, with counter cnt of width clog2(FILT_CYC) (minimum 1 bit):
  - If s_out == Q: cnt <= 0, no update.
  - If s_out != Q and cnt == FILT_CYC-1: Q <= s_out, cnt <= 0, update = 1.
  - If s_out != Q and cnt < FILT_CYC-1: cnt <= cnt+1.
  - cnt never exceeds FILT_CYC-1. It never wraps.
- Latency: D stable before edge e1 gives Q updated at edge e(STAGES+FILT_CYC).
- Pulse filtering: a D level held for fewer than FILT_CYC synchronised cycles never reaches Q. A level held for FILT_CYC or more always does.
- A bounce back to the Q level during counting clears cnt. The next deviation restarts counting from 0.
- Edge pulses:
  - RISE[i] <= update[i] & s_out[i]; FALL[i] <= update[i] & ~s_out[i]. Both are set at the same edge as Q.
  - Pulses last exactly one cycle. Two accepted transitions on a channel are at least FILT_CYC cycles apart, so pulses never merge.
- Channels are fully independent. Simultaneous updates on several channels raise their RISE/FALL bits together, and CHG stays high for that single cycle.
- Release from reset with D != RST_VAL: the transition is treated as a normal change. RISE/FALL fire after STAGES+FILT_CYC edges.
- Purely structural and synthesisable. There are no latches and no combinational paths from D to any output.

Test Plan:
1. WIDTH=4, STAGES=2, FILT_CYC=3, RST_VAL=4'b0101. Hold RST for 2 cycles, D=4'b0101, release -> Q=4'b0101, RISE=FALL=0, CHG=0 throughout.
2. Same config. D 0101->0111 before e1 -> Q=0111 at e5; RISE=0010 for exactly the cycle after e5; FALL=0; CHG high for 1 cycle.
3. Same config. D[3] pulses high for 2 cycles -> Q[3] stays 0, no RISE. D[3] pulses high for 3 cycles -> Q[3]=1 at e5 and RISE[3] pulses; FALL[3] pulses 3 cycles after the return to 0 is synchronised.
4. Same config. D[0] goes 1->0, then bounces to 1 for 1 cycle after 2 counted cycles, then returns to 0 -> counter restarts; Q[0] falls 3 full synchronised cycles after the final 0; a single FALL[0] pulse.
5. Same config. Assert RST for 1 cycle while cnt[1]=2 is pending on channel 1 -> no RISE/FALL; Q=0101 the cycle after reset; cnt=0.
6. WIDTH=1, STAGES=3, FILT_CYC=1 -> D 0->1 gives Q=1 at e4; RISE=1 for 1 cycle; toggling D every 2 cycles gives alternating RISE/FALL pulses 2 cycles apart.
